// File: rtl/fwd_hazard_ctrl_if.sv
// fwd_hazard_ctrl_if: ID-stage decode inputs and EXE operand-select outputs
interface fwd_hazard_ctrl_if;
  logic [4:0] rs, rt, rn;
  logic use_rs, use_rt, shift, aluimm, wmem, wreg, m2reg, btaken, stall;
  logic [1:0] ealusrc_a, ealusrc_b, store_src;
  modport master (
    output rs, rt, rn, use_rs, use_rt, shift, aluimm, wmem, wreg, m2reg, btaken,
    input  stall, ealusrc_a, ealusrc_b, store_src
  );
  modport slave (
    input  rs, rt, rn, use_rs, use_rt, shift, aluimm, wmem, wreg, m2reg, btaken,
    output stall, ealusrc_a, ealusrc_b, store_src
  );
endinterface

// File: rtl/fwd_hazard_ctrl.sv
// fwd_hazard_ctrl: EXE operand forwarding selects and load-use stall for a 5-stage MIPS pipe
module fwd_hazard_ctrl (
  input logic clk,
  input logic clrn,
  fwd_hazard_ctrl_if.slave bus
);
  logic [4:0] ern_q, ern_d, mrn_q, mrn_d;
  logic ewreg_q, ewreg_d, em2reg_q, em2reg_d, mwreg_q, mwreg_d;
  logic [1:0] a_q, a_d, b_q, b_d, s_q, s_d;
  logic e_fwd, m_fwd, e_load, stall;
  logic [1:0] rs_fwd, rt_fwd;
  assign bus.stall = stall;
  assign bus.ealusrc_a = a_q;
  assign bus.ealusrc_b = b_q;
  assign bus.store_src = s_q;
  // producer matching, stall detection and next values for shadows and selects; 00 in *_fwd means no forward
  always_comb begin
    e_fwd = ewreg_q & ~bus.btaken & (|ern_q);
    m_fwd = mwreg_q & (|mrn_q);
    e_load = e_fwd & em2reg_q;
    rs_fwd = (e_fwd & ~em2reg_q & (ern_q == bus.rs)) ? 2'b01 : (m_fwd & (mrn_q == bus.rs)) ? 2'b10 : 2'b00;
    rt_fwd = (e_fwd & ~em2reg_q & (ern_q == bus.rt)) ? 2'b01 : (m_fwd & (mrn_q == bus.rt)) ? 2'b10 : 2'b00;
    stall = e_load & ((bus.use_rs & ~bus.shift & (ern_q == bus.rs)) | ((bus.use_rt | bus.wmem) & (ern_q == bus.rt)));
    ern_d = bus.rn;
    ewreg_d = bus.wreg & ~stall;
    em2reg_d = bus.m2reg & ~stall;
    mrn_d = ern_q;
    mwreg_d = ewreg_q & ~bus.btaken;
    a_d = stall ? 2'b11 : bus.shift ? 2'b00 : (bus.use_rs && |rs_fwd) ? rs_fwd : 2'b11;
    b_d = stall ? 2'b11 : bus.aluimm ? 2'b00 : (bus.use_rt && |rt_fwd) ? rt_fwd : 2'b11;
    s_d = stall ? 2'b00 : bus.wmem ? rt_fwd : 2'b00;
  end
  // ID/EXE select registers and E/M destination shadows
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      ern_q <= '0;
      ewreg_q <= 1'b0;
      em2reg_q <= 1'b0;
      mrn_q <= '0;
      mwreg_q <= 1'b0;
      a_q <= 2'b11;
      b_q <= 2'b11;
      s_q <= 2'b00;
    end else begin
      ern_q <= ern_d;
      ewreg_q <= ewreg_d;
      em2reg_q <= em2reg_d;
      mrn_q <= mrn_d;
      mwreg_q <= mwreg_d;
      a_q <= a_d;
      b_q <= b_d;
      s_q <= s_d;
    end
  end
endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// tb_fwd_hazard_ctrl: scoreboard bench with an instruction-level pipeline model
module tb_fwd_hazard_ctrl;
  logic clk = 1'b0;
  logic clrn = 1'b0;
  fwd_hazard_ctrl_if bus();
  fwd_hazard_ctrl dut (.clk(clk), .clrn(clrn), .bus(bus));
  always #5 clk = ~clk;

  typedef struct packed { logic [4:0] dst; logic wr; logic ld; } instr_t;
  instr_t exe_m, mem_m;
  logic stall_exp[$];
  logic [5:0] sel_exp[$];
  int compared = 0;
  int mismatched = 0;
  bit run = 0;
  bit last_stall = 0;
  logic [5:0] mon_e;
  logic [4:0] r_rs, r_rt, r_rn;
  logic r_urs, r_urt, r_sh, r_imm, r_wm, r_wr, r_ld, r_bt;

  task automatic chk(input string nm, input logic [1:0] act, input logic [1:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  // where a source register's value comes from: 1 = ALU result in EXE, 2 = MEM stage, else dflt
  function automatic logic [1:0] src(input logic [4:0] r, input logic [1:0] dflt, input logic bt);
    if (r != 0 && exe_m.wr && !bt && exe_m.dst == r) return exe_m.ld ? dflt : 2'd1;
    if (r != 0 && mem_m.wr && mem_m.dst == r) return 2'd2;
    return dflt;
  endfunction

  task issue(input logic [4:0] rs_, rt_, rn_, input logic urs, urt, sh, imm, wm, wr, ld, bt);
    logic st;
    logic [1:0] ea, eb, es;
    bus.rs = rs_; bus.rt = rt_; bus.rn = rn_;
    bus.use_rs = urs; bus.use_rt = urt; bus.shift = sh; bus.aluimm = imm;
    bus.wmem = wm; bus.wreg = wr; bus.m2reg = ld; bus.btaken = bt;
    st = exe_m.wr && exe_m.ld && !bt && exe_m.dst != 0 &&
         ((urs && !sh && exe_m.dst == rs_) || ((urt || wm) && exe_m.dst == rt_));
    ea = st ? 2'd3 : sh ? 2'd0 : urs ? src(rs_, 2'd3, bt) : 2'd3;
    eb = st ? 2'd3 : imm ? 2'd0 : urt ? src(rt_, 2'd3, bt) : 2'd3;
    es = st ? 2'd0 : wm ? src(rt_, 2'd0, bt) : 2'd0;
    stall_exp.push_back(st);
    sel_exp.push_back({ea, eb, es});
    mem_m.dst = exe_m.dst;
    mem_m.wr = exe_m.wr && !bt;
    mem_m.ld = exe_m.ld && !bt;
    exe_m.dst = rn_;
    exe_m.wr = wr && !st;
    exe_m.ld = ld && !st;
    last_stall = st;
    @(posedge clk);
    #2;
  endtask

  task drive_nop();
    bus.rs = 0; bus.rt = 0; bus.rn = 0; bus.use_rs = 0; bus.use_rt = 0; bus.shift = 0;
    bus.aluimm = 0; bus.wmem = 0; bus.wreg = 0; bus.m2reg = 0; bus.btaken = 0;
  endtask

  always @(negedge clk) begin
    if (run) begin
      if (stall_exp.size() > 0) chk("stall", {1'b0, bus.stall}, {1'b0, stall_exp.pop_front()});
      if (sel_exp.size() > 0) begin
        mon_e = sel_exp.pop_front();
        chk("ealusrc_a", bus.ealusrc_a, mon_e[5:4]);
        chk("ealusrc_b", bus.ealusrc_b, mon_e[3:2]);
        chk("store_src", bus.store_src, mon_e[1:0]);
      end
    end
  end

  initial begin
    exe_m = '0;
    mem_m = '0;
    drive_nop();
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #2;
      {bus.rs, bus.rt, bus.rn} = 15'($urandom);
      {bus.use_rs, bus.use_rt, bus.shift, bus.aluimm, bus.wmem, bus.wreg, bus.m2reg, bus.btaken} = 8'($urandom);
      @(negedge clk);
      chk("rst_stall", {1'b0, bus.stall}, 2'b00);
      chk("rst_a", bus.ealusrc_a, 2'b11);
      chk("rst_b", bus.ealusrc_b, 2'b11);
      chk("rst_store", bus.store_src, 2'b00);
    end
    drive_nop();
    clrn = 1'b1;
    @(posedge clk);
    #2;
    sel_exp.push_back({2'd3, 2'd3, 2'd0});
    run = 1;
    issue(1, 2, 3, 1, 1, 0, 0, 0, 1, 0, 0);
    issue(2, 3, 1, 1, 1, 0, 0, 0, 1, 0, 0);
    issue(1, 1, 4, 1, 1, 0, 0, 0, 1, 0, 0);
    issue(2, 3, 1, 1, 1, 0, 0, 0, 1, 0, 0);
    issue(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    issue(1, 0, 5, 1, 1, 0, 0, 0, 1, 0, 0);
    issue(1, 0, 2, 1, 0, 0, 1, 0, 1, 1, 0);
    issue(2, 4, 3, 1, 1, 0, 0, 0, 1, 0, 0);
    issue(2, 4, 3, 1, 1, 0, 0, 0, 1, 0, 0);
    issue(2, 3, 6, 1, 1, 0, 0, 0, 1, 0, 0);
    issue(1, 6, 0, 1, 0, 0, 1, 1, 0, 0, 0);
    issue(1, 0, 6, 1, 0, 0, 1, 0, 1, 1, 0);
    issue(1, 6, 0, 1, 0, 0, 1, 1, 0, 0, 0);
    issue(1, 6, 0, 1, 0, 0, 1, 1, 0, 0, 0);
    issue(1, 2, 0, 1, 1, 0, 0, 0, 1, 0, 0);
    issue(0, 0, 8, 1, 1, 0, 0, 0, 1, 0, 0);
    issue(1, 2, 7, 1, 1, 0, 0, 0, 1, 0, 0);
    issue(7, 7, 9, 1, 1, 0, 0, 0, 1, 0, 1);
    issue(7, 7, 10, 1, 1, 0, 0, 0, 1, 0, 0);
    issue(1, 0, 2, 1, 0, 0, 1, 0, 1, 1, 0);
    issue(2, 4, 3, 1, 1, 0, 0, 0, 1, 0, 1);
    issue(2, 3, 1, 1, 1, 0, 0, 0, 1, 0, 0);
    issue(4, 5, 1, 1, 1, 0, 0, 0, 1, 0, 0);
    issue(1, 1, 11, 1, 1, 0, 0, 0, 1, 0, 0);
    issue(2, 3, 1, 1, 1, 0, 0, 0, 1, 0, 0);
    issue(0, 1, 5, 0, 1, 1, 0, 0, 1, 0, 0);
    for (int i = 0; i < 400; i++) begin
      if (!last_stall) begin
        r_rs = 5'($urandom_range(0, 3));
        r_rt = 5'($urandom_range(0, 3));
        r_rn = 5'($urandom_range(0, 3));
        {r_urs, r_urt, r_sh, r_imm, r_wm, r_wr, r_ld} = 7'($urandom);
      end
      r_bt = ($urandom_range(0, 7) == 0);
      issue(r_rs, r_rt, r_rn, r_urs, r_urt, r_sh, r_imm, r_wm, r_wr, r_ld, r_bt);
    end
    @(negedge clk);
    #1;
    run = 0;
    stall_exp.delete();
    sel_exp.delete();
    drive_nop();
    bus.rn = 2; bus.wreg = 1; bus.m2reg = 1;
    @(posedge clk);
    #2;
    drive_nop();
    bus.rs = 2; bus.use_rs = 1; bus.rn = 3; bus.wreg = 1;
    #1;
    chk("midstall_pre", {1'b0, bus.stall}, 2'b01);
    clrn = 1'b0;
    #1;
    chk("midstall_rst", {1'b0, bus.stall}, 2'b00);
    chk("midstall_a", bus.ealusrc_a, 2'b11);
    chk("midstall_store", bus.store_src, 2'b00);
    @(negedge clk);
    clrn = 1'b1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
